mem_ls_unit: RTL and testbench

Parametrised load/store sequencer between the execute stage and a synchronous data BRAM. It generalises the single-cycle load/store handshake to:
- configurable BRAM read latency;
- byte, half and word access sizes with per-byte write enables;
- signed or unsigned load extension;
- an explicit busy signal, with optional misalignment trapping.

It sits between the ALU/decoder and the data memory port, and feeds the writeback stage.

---
 rtl/mem_ls_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_ls_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ls_unit.sv
// mem_ls_unit: load/store sequencer between execute and a synchronous data BRAM.
// Handles configurable BRAM read latency, byte/half/word accesses with per-byte
// write enables, signed/unsigned load extension and a busy handshake.
// Optional feature macro: MEM_LS_MISALIGN_TRAP_EN rejects misaligned half/word
// accesses with a one-cycle misalign pulse. When the macro is undefined,
// misalign is tied low and misaligned offsets are truncated.
module mem_ls_unit #(
  parameter int ADDR_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int WORD_ADDR = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              l_valid,
  input  logic              s_valid,
  input  logic [1:0]        size,
  input  logic              l_unsigned,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [31:0]       s_data,
  input  logic [31:0]       d_dout,
  output logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_din,
  output logic [3:0]        wea,
  output logic [31:0]       load_data,
  output logic              load_finish,
  output logic              store_finish,
  output logic              busy,
  output logic              misalign
);

  localparam int         DATA_W  = 32;
  localparam logic [2:0] LAT_CNT = 3'(RD_LAT);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WR, DONE} state_t;

  state_t            state_p0;
  logic [2:0]        cnt_p0;
  logic [1:0]        off_p0;
  logic [1:0]        size_p0;
  logic              uns_p0;
  logic [ADDR_W-1:0] addr_map;
  logic [1:0]        off_in;
  logic              mis_req;
  logic              ld_go;
  logic              st_go;

  // Extract the addressed lane(s) from the BRAM word and extend to 32 bits.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] sz,
                                                    input logic [1:0] off,
                                                    input logic uns);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic [DATA_W-1:0]  res;
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   res = uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   res = uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replicate right-aligned store data across every lane it may land in.
  function automatic logic [DATA_W-1:0] lane_rep(input logic [DATA_W-1:0] sd,
                                                 input logic [1:0] sz);
    case (sz)
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  // Per-byte write enables for the addressed lane(s).
  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign off_in   = alu_out[1:0];
  assign addr_map = (WORD_ADDR != 0) ? (alu_out >> 2) : {alu_out[ADDR_W-1:2], 2'b00};

`ifdef MEM_LS_MISALIGN_TRAP_EN
  // Half needs an even offset, word (and size 11) needs offset 0.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  logic mis_p0;

  assign mis_req = is_misaligned(size, off_in);

  // One-cycle trap pulse for a misaligned request seen while idle.
  always_ff @(posedge clk) begin
    if (!rstn) mis_p0 <= 1'b0;
    else       mis_p0 <= (l_valid | s_valid) & ~busy & mis_req;
  end

  assign misalign = mis_p0;
`else
  assign mis_req  = 1'b0;
  assign misalign = 1'b0;
`endif

  // Load wins over a simultaneous store; nothing is accepted while busy.
  assign ld_go = l_valid & ~busy & ~mis_req;
  assign st_go = s_valid & ~l_valid & ~busy & ~mis_req;

  // Sequencer FSM with all memory-side and result outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_p0     <= IDLE;
      cnt_p0       <= '0;
      off_p0       <= '0;
      size_p0      <= '0;
      uns_p0       <= 1'b0;
      d_addr       <= '0;
      d_din        <= '0;
      wea          <= '0;
      load_data    <= '0;
      load_finish  <= 1'b0;
      store_finish <= 1'b0;
      busy         <= 1'b0;
    end else begin
      wea          <= '0;
      load_finish  <= 1'b0;
      store_finish <= 1'b0;
      case (state_p0)
        IDLE, DONE: begin
          state_p0 <= IDLE;
          busy     <= 1'b0;
          if (ld_go) begin
            d_addr   <= addr_map;
            off_p0   <= off_in;
            size_p0  <= size;
            uns_p0   <= l_unsigned;
            cnt_p0   <= '0;
            busy     <= 1'b1;
            state_p0 <= LOAD_WAIT;
          end else if (st_go) begin
            d_addr   <= addr_map;
            d_din    <= lane_rep(s_data, size);
            wea      <= byte_mask(size, off_in);
            busy     <= 1'b1;
            state_p0 <= STORE_WR;
          end
        end
        LOAD_WAIT: begin
          // BRAM data is valid once the counter has covered the read latency.
          if (cnt_p0 == LAT_CNT) begin
            load_data   <= extend_load(d_dout, size_p0, off_p0, uns_p0);
            load_finish <= 1'b1;
            busy        <= 1'b0;
            state_p0    <= DONE;
          end else begin
            cnt_p0 <= cnt_p0 + 3'd1;
          end
        end
        STORE_WR: begin
          store_finish <= 1'b1;
          busy         <= 1'b0;
          state_p0     <= DONE;
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ls_unit.sv
// Testbench for mem_ls_unit: two instances (RD_LAT=3 word-addressed, RD_LAT=1
// byte-addressed) share one stimulus stream; each has its own BRAM model and
// scoreboard queues of expected loads and stores.
module tb_mem_ls_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        l_valid, s_valid, l_unsigned;
  logic [1:0]  size;
  logic [31:0] alu_out, s_data;

  logic [31:0] a_d_dout, a_d_addr, a_d_din, a_load_data;
  logic [3:0]  a_wea;
  logic        a_load_finish, a_store_finish, a_busy, a_misalign;
  logic [31:0] b_d_dout, b_d_addr, b_d_din, b_load_data;
  logic [3:0]  b_wea;
  logic        b_load_finish, b_store_finish, b_busy, b_misalign;

  typedef struct { logic [31:0] data; int due; } ld_t;
  typedef struct { logic [31:0] addr; logic [31:0] din; logic [3:0] wea; int due; } st_t;

  ld_t qla[$], qlb[$];
  st_t qsa[$], qsb[$];
  int  sf_due_a = -1, sf_due_b = -1, mis_due = -1;
  int  total = 0, bad = 0, cyc = 0;

  logic [31:0] mem [0:63];
  logic [31:0] pa [0:2];
  logic [31:0] pb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models: registered read pipelines of depth RD_LAT.
  always @(posedge clk) begin
    pa[0] <= mem[6'(a_d_addr)];
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pb    <= mem[6'(b_d_addr >> 2)];
  end
  assign a_d_dout = pa[2];
  assign b_d_dout = pb;

  mem_ls_unit #(.ADDR_W(32), .RD_LAT(3), .WORD_ADDR(1)) u_a (
    .clk(clk), .rstn(rstn), .l_valid(l_valid), .s_valid(s_valid), .size(size),
    .l_unsigned(l_unsigned), .alu_out(alu_out), .s_data(s_data), .d_dout(a_d_dout),
    .d_addr(a_d_addr), .d_din(a_d_din), .wea(a_wea), .load_data(a_load_data),
    .load_finish(a_load_finish), .store_finish(a_store_finish), .busy(a_busy),
    .misalign(a_misalign));

  mem_ls_unit #(.ADDR_W(32), .RD_LAT(1), .WORD_ADDR(0)) u_b (
    .clk(clk), .rstn(rstn), .l_valid(l_valid), .s_valid(s_valid), .size(size),
    .l_unsigned(l_unsigned), .alu_out(alu_out), .s_data(s_data), .d_dout(b_d_dout),
    .d_addr(b_d_addr), .d_din(b_d_din), .wea(b_wea), .load_data(b_load_data),
    .load_finish(b_load_finish), .store_finish(b_store_finish), .busy(b_busy),
    .misalign(b_misalign));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] off, input logic uns);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (int'(off) * 8)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_din(input logic [31:0] sd, input logic [1:0] sz);
    if (sz == 2'b00) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] m_wea(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'b00) return 4'(1 << int'(off));
    if (sz == 2'b01) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic word);
    return word ? (a >> 2) : (a & 32'hFFFF_FFFC);
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [1:0] off);
    logic r;
    r = (sz == 2'b01 && off[0]) || (sz >= 2'b10 && off != 2'b00);
`ifdef MEM_LS_MISALIGN_TRAP_EN
    return r;
`else
    return r & 1'b0;
`endif
  endfunction

  task automatic mon();
    ld_t le;
    st_t se;
    if (a_load_finish) begin
      if (qla.size() == 0) chk("a_lf_unexpected", 32'd1, 32'd0);
      else begin
        le = qla.pop_front();
        chk("a_ld_data", a_load_data, le.data);
        chk("a_ld_cycle", cyc, le.due);
      end
    end else if (qla.size() > 0 && cyc > qla[0].due) begin
      chk("a_ld_timeout", 32'd0, 32'd1);
      void'(qla.pop_front());
    end
    if (b_load_finish) begin
      if (qlb.size() == 0) chk("b_lf_unexpected", 32'd1, 32'd0);
      else begin
        le = qlb.pop_front();
        chk("b_ld_data", b_load_data, le.data);
        chk("b_ld_cycle", cyc, le.due);
      end
    end else if (qlb.size() > 0 && cyc > qlb[0].due) begin
      chk("b_ld_timeout", 32'd0, 32'd1);
      void'(qlb.pop_front());
    end
    if (a_wea != 4'h0) begin
      if (qsa.size() == 0) chk("a_wea_unexpected", a_wea, 32'd0);
      else begin
        se = qsa.pop_front();
        chk("a_wea", a_wea, se.wea);
        chk("a_d_din", a_d_din, se.din);
        chk("a_st_addr", a_d_addr, se.addr);
        chk("a_wea_cycle", cyc, se.due);
        sf_due_a = cyc + 1;
      end
    end else if (qsa.size() > 0 && cyc > qsa[0].due) begin
      chk("a_st_timeout", 32'd0, 32'd1);
      void'(qsa.pop_front());
    end
    if (b_wea != 4'h0) begin
      if (qsb.size() == 0) chk("b_wea_unexpected", b_wea, 32'd0);
      else begin
        se = qsb.pop_front();
        chk("b_wea", b_wea, se.wea);
        chk("b_d_din", b_d_din, se.din);
        chk("b_st_addr", b_d_addr, se.addr);
        chk("b_wea_cycle", cyc, se.due);
        sf_due_b = cyc + 1;
      end
    end else if (qsb.size() > 0 && cyc > qsb[0].due) begin
      chk("b_st_timeout", 32'd0, 32'd1);
      void'(qsb.pop_front());
    end
    if (a_store_finish || cyc == sf_due_a) chk("a_store_finish", a_store_finish, cyc == sf_due_a);
    if (b_store_finish || cyc == sf_due_b) chk("b_store_finish", b_store_finish, cyc == sf_due_b);
    if (a_misalign || b_misalign || cyc == mis_due) begin
      chk("a_misalign", a_misalign, cyc == mis_due);
      chk("b_misalign", b_misalign, cyc == mis_due);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    mon();
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic req(input logic lv, input logic sv, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] sd,
                     input logic acc_a, input logic acc_b);
    int  k;
    ld_t le;
    st_t se;
    k = cyc + 1;
    l_valid = lv; s_valid = sv; size = sz; l_unsigned = uns; alu_out = addr; s_data = sd;
    if ((lv || sv) && m_mis(sz, addr[1:0]) && (acc_a || acc_b)) begin
      mis_due = k;
    end else if (lv) begin
      le.data = m_load(mem[6'(addr >> 2)], sz, addr[1:0], uns);
      if (acc_a) begin le.due = k + 4; qla.push_back(le); end
      if (acc_b) begin le.due = k + 2; qlb.push_back(le); end
    end else if (sv) begin
      se.din = m_din(sd, sz);
      se.wea = m_wea(sz, addr[1:0]);
      se.due = k;
      if (acc_a) begin se.addr = m_addr(addr, 1'b1); qsa.push_back(se); end
      if (acc_b) begin se.addr = m_addr(addr, 1'b0); qsb.push_back(se); end
    end
    tick();
    l_valid = 1'b0; s_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_d_addr"}, a_d_addr, 32'd0);
    chk({tag, "_a_d_din"}, a_d_din, 32'd0);
    chk({tag, "_a_wea"}, a_wea, 32'd0);
    chk({tag, "_a_load_data"}, a_load_data, 32'd0);
    chk({tag, "_a_lf"}, a_load_finish, 32'd0);
    chk({tag, "_a_sf"}, a_store_finish, 32'd0);
    chk({tag, "_a_busy"}, a_busy, 32'd0);
    chk({tag, "_a_mis"}, a_misalign, 32'd0);
    chk({tag, "_b_d_addr"}, b_d_addr, 32'd0);
    chk({tag, "_b_d_din"}, b_d_din, 32'd0);
    chk({tag, "_b_wea"}, b_wea, 32'd0);
    chk({tag, "_b_load_data"}, b_load_data, 32'd0);
    chk({tag, "_b_lf"}, b_load_finish, 32'd0);
    chk({tag, "_b_sf"}, b_store_finish, 32'd0);
    chk({tag, "_b_busy"}, b_busy, 32'd0);
    chk({tag, "_b_mis"}, b_misalign, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (32'h0101_0101 * i) ^ 32'h5A00_0000;
    rstn = 1'b0; l_valid = 1'b0; s_valid = 1'b0; l_unsigned = 1'b0;
    size = 2'b00; alu_out = 32'd0; s_data = 32'd0;
    @(negedge clk);
    drain(2);
    chk_zero("reset");
    rstn = 1'b1;
    drain(1);

    // Word load at 0x10.
    mem[4] = 32'hDEAD_BEEF;
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1);
    chk("b_addr_word", b_d_addr, 32'h10);
    chk("a_addr_index", a_d_addr, 32'h4);
    chk("a_busy_load", a_busy, 32'd1);
    chk("b_busy_load", b_busy, 32'd1);
    drain(6);
    chk("b_load_hold", b_load_data, 32'hDEAD_BEEF);
    chk("a_busy_idle", a_busy, 32'd0);

    // Byte/half loads with sign and zero extension.
    mem[4] = 32'h8011_2233;
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b1, 1'b1);
    drain(6);
    chk("a_byte_signed", a_load_data, 32'hFFFF_FF80);
    req(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1'b1, 1'b1);
    drain(6);
    chk("a_byte_unsigned", a_load_data, 32'h0000_0080);
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 1'b1, 1'b1);
    drain(6);
    req(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'd0, 1'b1, 1'b1);
    drain(6);

    // Half and byte stores.
    req(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, 1'b1, 1'b1);
    chk("b_busy_store", b_busy, 32'd1);
    tick();
    chk("b_wea_one_cycle", b_wea, 32'd0);
    chk("b_busy_after_store", b_busy, 32'd0);
    drain(3);
    chk("b_din_hold", b_d_din, 32'hABCD_ABCD);
    req(1'b0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h1234_565A, 1'b1, 1'b1);
    drain(3);

    // Simultaneous load+store, then a store while busy: only the load happens.
    req(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF, 1'b1, 1'b1);
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h7777_7777, 1'b0, 1'b0);
    drain(6);

    // Back-to-back on the RD_LAT=1 instance: new request in its finish cycle.
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1);
    tick();
    tick();
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFE_F00D, 1'b0, 1'b1);
    drain(6);

    // Reset during LOAD_WAIT abandons the access.
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1, 1'b1);
    qla.delete();
    qlb.delete();
    rstn = 1'b0;
    tick();
    chk_zero("midreset");
    rstn = 1'b1;
    drain(6);
    req(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 1'b1, 1'b1);
    drain(6);

    // Misaligned word store at 0x05 and misaligned half load at 0x11.
    req(1'b0, 1'b1, 2'b10, 1'b0, 32'h05, 32'h1122_3344, 1'b1, 1'b1);
    chk("b_mis_store_pulse", b_misalign, m_mis(2'b10, 2'b01));
    drain(3);
    req(1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 1'b1, 1'b1);
    drain(6);

    chk("queues_empty", qla.size() + qlb.size() + qsa.size() + qsb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
